debounce_bank: RTL and testbench

//  Multi-channel debouncer with a runtime-programmable settle time, for Hall

---
 rtl/debounce_bank_if.sv | 23 ++
 rtl/debounce_bank.sv | 90 +++++++++
 tb/tb_debounce_bank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
// Signal bundle for debounce_bank: raw inputs, debounced levels and strobes.
interface debounce_bank_if #(
  parameter int unsigned CHANNELS = 3
);
  logic [CHANNELS-1:0] signal_in;
  logic [CHANNELS-1:0] signal_out;
  logic [CHANNELS-1:0] signal_up;
  logic [CHANNELS-1:0] signal_down;
  logic [CHANNELS-1:0] signal_change;
  logic                change_any;

  // Source of the raw inputs and consumer of the debounced results
  modport master (
    output signal_in,
    input  signal_out, signal_up, signal_down, signal_change, change_any
  );

  // The debouncer itself
  modport slave (
    input  signal_in,
    output signal_out, signal_up, signal_down, signal_change, change_any
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: 2-FF synchroniser, per-channel settle counter with
// a live threshold, registered rise/fall/change strobes and a saturating
// bank-wide counter of aborted transitions.
module debounce_bank #(
  parameter int unsigned         CHANNELS  = 3,
  parameter int unsigned         CNT_W     = 12,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0,
  parameter int unsigned         GLITCH_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CNT_W-1:0]    threshold,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt_o,
  debounce_bank_if.slave      bus
);

  logic [CHANNELS-1:0] sync0;
  logic [CHANNELS-1:0] sync1;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] idle;
  logic [CHANNELS-1:0] abort;
  logic [CHANNELS-1:0] commit;

  // Two-stage synchroniser; runs regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= RESET_VAL;
      sync1 <= RESET_VAL;
    end else begin
      sync0 <= bus.signal_in;
      sync1 <= sync0;
    end
  end

  // Per-channel decision: abandon a pending transition, commit it, or keep counting
  always_comb begin
    idle   = '0;
    abort  = '0;
    commit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idle[i]   = (bus.signal_out[i] == sync1[i]);
      abort[i]  = enable && idle[i] && (cnt[i] != '0);
      commit[i] = enable && !idle[i] && (cnt[i] >= threshold);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    // Settle counter; >= compare means it never wraps and a lowered threshold commits next cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[g] <= '0;
      end else if (!enable || idle[g] || commit[g]) begin
        cnt[g] <= '0;
      end else begin
        cnt[g] <= cnt[g] + CNT_W'(1);
      end
    end
  end

  // Debounced levels and one-cycle strobes, all updated on the commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.signal_out    <= RESET_VAL;
      bus.signal_up     <= '0;
      bus.signal_down   <= '0;
      bus.signal_change <= '0;
      bus.change_any    <= 1'b0;
    end else begin
      bus.signal_out    <= (bus.signal_out & ~commit) | (sync1 & commit);
      bus.signal_up     <= commit & sync1;
      bus.signal_down   <= commit & ~sync1;
      bus.signal_change <= commit;
      bus.change_any    <= |commit;
    end
  end

  // Glitch counter: clear wins, one count per cycle with any abort, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_o <= '0;
    end else if (glitch_clr) begin
      glitch_cnt_o <= '0;
    end else if ((|abort) && (glitch_cnt_o != '1)) begin
      glitch_cnt_o <= glitch_cnt_o + GLITCH_W'(1);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (3 channels, 4-bit glitch counter).
module tb_debounce_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] threshold;
  logic        glitch_clr;
  logic [3:0]  glitch_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  debounce_bank_if #(.CHANNELS(3)) bus ();

  debounce_bank #(
    .CHANNELS (3),
    .CNT_W    (12),
    .RESET_VAL(3'b100),
    .GLITCH_W (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .threshold   (threshold),
    .glitch_clr  (glitch_clr),
    .glitch_cnt_o(glitch_cnt_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic [2:0] up, input logic [2:0] dn);
    chk({tag, "_up"},   32'(bus.signal_up),     32'(up));
    chk({tag, "_down"}, 32'(bus.signal_down),   32'(dn));
    chk({tag, "_chg"},  32'(bus.signal_change), 32'(up | dn));
    chk({tag, "_any"},  32'(bus.change_any),    32'(|(up | dn)));
  endtask

  initial begin
    rst_n         = 1'b1;
    enable        = 1'b0;
    threshold     = 12'd10;
    glitch_clr    = 1'b0;
    bus.signal_in = 3'b100;

    // 1: asynchronous reset asserted between edges takes effect immediately
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(bus.signal_out), 32'h4);
    chk_strobes("rst", 3'b000, 3'b000);
    chk("rst_glitch", 32'(glitch_cnt_o), 32'h0);
    tick(2);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(3);
    chk("idle_out", 32'(bus.signal_out), 32'h4);

    // 2: ch0 rises with threshold 10 -> commit at edge 13
    bus.signal_in = 3'b101;
    tick(12);
    chk("rise_pre", 32'(bus.signal_out), 32'h4);
    tick(1);
    chk("rise_out", 32'(bus.signal_out), 32'h5);
    chk_strobes("rise", 3'b001, 3'b000);
    tick(1);
    chk_strobes("rise_after", 3'b000, 3'b000);

    // 3: 5-cycle pulse on ch1 is rejected and counted as a glitch
    bus.signal_in = 3'b111;
    tick(5);
    bus.signal_in = 3'b101;
    tick(2);
    chk("pulse_glitch_pre", 32'(glitch_cnt_o), 32'h0);
    tick(1);
    chk("pulse_glitch", 32'(glitch_cnt_o), 32'h1);
    chk("pulse_out", 32'(bus.signal_out), 32'h5);
    // clear coincides with the next abort -> clear wins
    bus.signal_in = 3'b111;
    tick(3);
    bus.signal_in = 3'b101;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    chk("clr_prio", 32'(glitch_cnt_o), 32'h0);
    glitch_clr = 1'b0;
    tick(1);
    chk("clr_hold", 32'(glitch_cnt_o), 32'h0);

    // 4: ch0 and ch2 fall together with threshold 20
    threshold     = 12'd20;
    bus.signal_in = 3'b000;
    tick(22);
    chk("pair_pre", 32'(bus.signal_out), 32'h5);
    tick(1);
    chk("pair_out", 32'(bus.signal_out), 32'h0);
    chk_strobes("pair", 3'b000, 3'b101);
    tick(1);
    chk_strobes("pair_after", 3'b000, 3'b000);
    // rise again; drop threshold to 3 once the counters reach 8
    bus.signal_in = 3'b101;
    tick(10);
    chk("lower_pre", 32'(bus.signal_out), 32'h0);
    threshold = 12'd3;
    tick(1);
    chk("lower_out", 32'(bus.signal_out), 32'h5);
    chk_strobes("lower", 3'b101, 3'b000);

    // 5: raise ch1, then disable during its fall
    bus.signal_in = 3'b111;
    tick(6);
    chk("ch1_up_out", 32'(bus.signal_out), 32'h7);
    chk_strobes("ch1_up", 3'b010, 3'b000);
    bus.signal_in = 3'b101;
    tick(4);
    enable = 1'b0;
    tick(5);
    chk("dis_out", 32'(bus.signal_out), 32'h7);
    chk("dis_glitch", 32'(glitch_cnt_o), 32'h0);
    chk("dis_any", 32'(bus.change_any), 32'h0);
    enable = 1'b1;
    tick(3);
    chk("reen_pre", 32'(bus.signal_out), 32'h7);
    tick(1);
    chk("reen_out", 32'(bus.signal_out), 32'h5);
    chk_strobes("reen", 3'b000, 3'b010);
    chk("reen_glitch", 32'(glitch_cnt_o), 32'h0);

    // 6: threshold 0 -> commit at edge 3
    threshold     = 12'd0;
    bus.signal_in = 3'b111;
    tick(2);
    chk("thr0_pre", 32'(bus.signal_out), 32'h5);
    tick(1);
    chk("thr0_out", 32'(bus.signal_out), 32'h7);
    chk_strobes("thr0", 3'b010, 3'b000);

    // simultaneous aborts on two channels count once
    threshold     = 12'd10;
    bus.signal_in = 3'b010;
    tick(2);
    bus.signal_in = 3'b111;
    tick(4);
    chk("multi_abort", 32'(glitch_cnt_o), 32'h1);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    chk("clr_again", 32'(glitch_cnt_o), 32'h0);

    // 20 isolated bounces on ch0 -> saturates at 15
    for (int i = 0; i < 20; i++) begin
      bus.signal_in = 3'b110;
      tick(2);
      bus.signal_in = 3'b111;
      tick(4);
      if (i == 13) chk("sat_mid", 32'(glitch_cnt_o), 32'hE);
    end
    chk("sat_glitch", 32'(glitch_cnt_o), 32'hF);
    chk("sat_out", 32'(bus.signal_out), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
